// File: rtl/clk_div.sv
// ----------------------------------------------------------------------------
// clk_div
//   Two-stage divider producing a fast and a slow 50%-duty square wave from
//   clkin. Stage 1 toggles clk_1kHz every HALF1 clkin cycles. Stage 2 is a
//   clock-enabled counter in the clkin domain. It advances once per clk_1kHz
//   rising edge and toggles clk_4Hz every HALF2 such advances.
//
// Ports
//   clkin     in   system clock, rising-edge active
//   clrn      in   asynchronous active-low reset
//   clk_1kHz  out  fast square wave, registered
//   clk_4Hz   out  slow square wave, registered
// ----------------------------------------------------------------------------
module clk_div #(
    parameter int CLK_HZ  = 50000000,
    parameter int FAST_HZ = 1000,
    parameter int SLOW_HZ = 4
) (
    input  logic clkin,
    input  logic clrn,
    output logic clk_1kHz,
    output logic clk_4Hz
);

    localparam int HALF1 = CLK_HZ / (2 * FAST_HZ);
    localparam int HALF2 = FAST_HZ / (2 * SLOW_HZ);

    localparam logic [14:0] HALF1_M1 = 15'(HALF1 - 1);
    localparam logic [7:0]  HALF2_M1 = 8'(HALF2 - 1);

    // Reject parameter sets that the fixed-width counters cannot hold.
    if (HALF1 < 1 || HALF1 > 32768) begin : g_bad_half1
        $error("clk_div: HALF1 out of range for 15-bit count1");
    end
    if (HALF2 < 1 || HALF2 > 256) begin : g_bad_half2
        $error("clk_div: HALF2 out of range for 8-bit count2");
    end

    // Register names are kept short and fixed so benches can observe them.
    logic [14:0] count1, count1_d;
    logic [7:0]  count2, count2_d;
    logic        clk_1kHz_d, clk_4Hz_d;
    logic        wrap1, tick;

    always_comb begin
        wrap1      = (count1 == HALF1_M1);
        // Advance stage 2 only on the wrap that makes clk_1kHz rise.
        tick       = wrap1 && !clk_1kHz;
        count1_d   = wrap1 ? 15'd0 : count1 + 15'd1;
        clk_1kHz_d = clk_1kHz ^ wrap1;
        count2_d   = count2;
        clk_4Hz_d  = clk_4Hz;
        if (tick) begin
            if (count2 == HALF2_M1) begin
                count2_d  = 8'd0;
                clk_4Hz_d = ~clk_4Hz;
            end else begin
                count2_d  = count2 + 8'd1;
            end
        end
    end

    always_ff @(posedge clkin or negedge clrn) begin
        if (!clrn) begin
            count1   <= 15'd0;
            count2   <= 8'd0;
            clk_1kHz <= 1'b0;
            clk_4Hz  <= 1'b0;
        end else begin
            count1   <= count1_d;
            count2   <= count2_d;
            clk_1kHz <= clk_1kHz_d;
            clk_4Hz  <= clk_4Hz_d;
        end
    end

endmodule

// File: tb/tb_clk_div.sv
// ----------------------------------------------------------------------------
// tb_clk_div
//   Drives two clk_div instances from one clkin/clrn:
//     u_big : default parameters, HALF1=25000, HALF2=125
//     u_sm  : CLK_HZ=1000, FAST_HZ=100, SLOW_HZ=10, so HALF1=5 and HALF2=5
//   The timing of u_sm was worked out by hand for the vector table. In u_sm,
//   clk_1kHz toggles every 5 edges, count2 advances on edges 5, 15, 25 and
//   so on, and clk_4Hz first rises at edge 45 with a period of 100 edges.
// ----------------------------------------------------------------------------
module tb_clk_div;

    logic clkin = 1'b0;
    logic clrn  = 1'b0;
    logic big_f, big_s, sm_f, sm_s;

    int n     = 0;   // counted rising edges since the last clrn release
    int n_cmp = 0;
    int n_mis = 0;

    clk_div u_big (
        .clkin    (clkin),
        .clrn     (clrn),
        .clk_1kHz (big_f),
        .clk_4Hz  (big_s)
    );

    clk_div #(.CLK_HZ(1000), .FAST_HZ(100), .SLOW_HZ(10)) u_sm (
        .clkin    (clkin),
        .clrn     (clrn),
        .clk_1kHz (sm_f),
        .clk_4Hz  (sm_s)
    );

    always #10 clkin = ~clkin;

    typedef struct {
        int n;
        int c1;
        int c2;
        int f;
        int s;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    // Advance one rising edge and return on the following falling edge.
    task automatic step();
        @(posedge clkin);
        n = n + 1;
        @(negedge clkin);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " big count1"}, int'(u_big.count1), 0);
        check({tag, " big count2"}, int'(u_big.count2), 0);
        check({tag, " big clk_1kHz"}, int'(big_f), 0);
        check({tag, " big clk_4Hz"}, int'(big_s), 0);
        check({tag, " sm count1"}, int'(u_sm.count1), 0);
        check({tag, " sm count2"}, int'(u_sm.count2), 0);
        check({tag, " sm clk_1kHz"}, int'(sm_f), 0);
        check({tag, " sm clk_4Hz"}, int'(sm_s), 0);
    endtask

    initial begin
        int first_f, first_s, bad_big, bad_sm, bad_at_big, bad_at_sm, max_c2;

        //           n    c1 c2 f  s
        tbl[0]  = '{  0,  0, 0, 0, 0};
        tbl[1]  = '{  4,  4, 0, 0, 0};
        tbl[2]  = '{  5,  0, 1, 1, 0};
        tbl[3]  = '{  9,  4, 1, 1, 0};
        tbl[4]  = '{ 10,  0, 1, 0, 0};
        tbl[5]  = '{ 15,  0, 2, 1, 0};
        tbl[6]  = '{ 44,  4, 4, 0, 0};
        tbl[7]  = '{ 45,  0, 0, 1, 1};
        tbl[8]  = '{ 50,  0, 0, 0, 1};
        tbl[9]  = '{ 94,  4, 4, 0, 1};
        tbl[10] = '{ 95,  0, 0, 1, 0};
        tbl[11] = '{100,  0, 0, 0, 0};
        tbl[12] = '{145,  0, 0, 1, 1};

        // Reset held across several edges.
        repeat (3) @(negedge clkin);
        check_all_zero("reset hold");

        // Release between edges; the first edge counted is the next posedge.
        clrn = 1'b1;
        n    = 0;
        for (int i = 0; i < 13; i++) begin
            while (n < tbl[i].n) step();
            check($sformatf("tbl[%0d] sm count1", i), int'(u_sm.count1), tbl[i].c1);
            check($sformatf("tbl[%0d] sm count2", i), int'(u_sm.count2), tbl[i].c2);
            check($sformatf("tbl[%0d] sm clk_1kHz", i), int'(sm_f), tbl[i].f);
            check($sformatf("tbl[%0d] sm clk_4Hz", i), int'(sm_s), tbl[i].s);
        end
        check("big count1 at 145", int'(u_big.count1), 145);

        // Mid-operation async reset, asserted between edges while the slow
        // output of u_sm is high. The state must clear before the next edge.
        step();  // edge 146
        #3 clrn = 1'b0;
        #1 check_all_zero("async reset");
        step();
        step();
        check_all_zero("reset low");

        // Release, then walk both instances edge by edge against closed-form
        // expectations through two full fast periods of u_big.
        clrn       = 1'b1;
        n          = 0;
        first_f    = -1;
        first_s    = -1;
        bad_big    = 0;
        bad_sm     = 0;
        bad_at_big = -1;
        bad_at_sm  = -1;
        max_c2     = 0;
        for (int k = 1; k <= 50000; k++) begin
            int tk;
            step();
            if (int'(u_big.count1) != (k % 25000) ||
                int'(big_f) != ((k / 25000) % 2) ||
                int'(u_big.count2) != (((k + 25000) / 50000) % 125) ||
                big_s !== 1'b0) begin
                if (bad_at_big < 0) bad_at_big = k;
                bad_big++;
            end
            tk = (k + 5) / 10;
            if (int'(u_sm.count1) != (k % 5) ||
                int'(sm_f) != ((k / 5) % 2) ||
                int'(u_sm.count2) != (tk % 5) ||
                int'(sm_s) != ((tk / 5) % 2)) begin
                if (bad_at_sm < 0) bad_at_sm = k;
                bad_sm++;
            end
            if (int'(u_sm.count2) > max_c2) max_c2 = int'(u_sm.count2);
            if (first_f < 0 && sm_f) first_f = k;
            if (first_s < 0 && sm_s) first_s = k;
            if (k == 24999) begin
                check("big count1 at 24999", int'(u_big.count1), 24999);
                check("big clk_1kHz at 24999", int'(big_f), 0);
                check("big count2 at 24999", int'(u_big.count2), 0);
            end
            if (k == 25000) begin
                check("big count1 wrap", int'(u_big.count1), 0);
                check("big clk_1kHz rise", int'(big_f), 1);
                check("big count2 on rise", int'(u_big.count2), 1);
            end
            if (k == 50000) begin
                check("big count1 2nd wrap", int'(u_big.count1), 0);
                check("big clk_1kHz fall", int'(big_f), 0);
                check("big count2 on fall", int'(u_big.count2), 1);
            end
        end
        check("big walk errors", bad_big, 0);
        if (bad_big != 0) $display("  first big deviation at edge %0d", bad_at_big);
        check("sm walk errors", bad_sm, 0);
        if (bad_sm != 0) $display("  first sm deviation at edge %0d", bad_at_sm);
        check("sm first clk_1kHz rise after reset", first_f, 5);
        check("sm first clk_4Hz rise after reset", first_s, 45);
        check("sm count2 max", max_c2, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
